tt_vector_driver: RTL and testbench

//  Stimulus and checking end for the 3/4/1-in, 3-out truth-table block (a, b, x -> y).

---
 rtl/tt_vector_driver.sv | 98 +++++++++
 tb/tb_tt_vector_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tt_vector_driver.sv
// tt_vector_driver: applies a loadable table of (a,b,x) vectors to a truth-table block,
// samples y after a settle time and reports mismatches and pass/fail.
module tt_vector_driver #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vec_we,
    input  logic [ADDR_W-1:0] vec_waddr,
    input  logic [10:0]       vec_wdata,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic [2:0]        dut_a,
    output logic [3:0]        dut_b,
    output logic              dut_x,
    input  logic [2:0]        dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_idx
);
    localparam int CW = $clog2(SETTLE + 1);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [10:0] mem [DEPTH];
    logic [10:0] vec;
    logic [ADDR_W:0] count;
    logic [ADDR_W-1:0] idx;
    logic [CW-1:0] settle_cnt;
    logic last, mismatch;
    assign vec      = mem[idx];
    assign last     = {1'b0, idx} == count - 1'b1;
    assign mismatch = dut_y != vec[2:0];
    assign busy     = state inside {DRIVE, WAIT, CHECK};
    assign done     = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start ? (num_vec == '0 ? DONE : DRIVE) : IDLE;
            DRIVE: state_n = WAIT;
            WAIT:  state_n = settle_cnt == CW'(1) ? CHECK : WAIT;
            CHECK: state_n = last ? DONE : DRIVE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // table contents survive reset; writes only land while idle
    always_ff @(posedge clk)
        if (!rst && vec_we && state == IDLE) mem[vec_waddr] <= vec_wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            idx           <= '0;
            settle_cnt    <= '0;
            {dut_a, dut_b, dut_x} <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    count         <= num_vec > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : num_vec;
                    idx           <= '0;
                    pass          <= 1'b0;
                    err_count     <= '0;
                    first_err_vld <= 1'b0;
                    first_err_idx <= '0;
                end
                DRIVE: begin
                    {dut_a, dut_b, dut_x} <= vec[10:3];
                    settle_cnt <= CW'(SETTLE);
                end
                WAIT: settle_cnt <= settle_cnt - 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        err_count <= &err_count ? err_count : err_count + 1'b1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= idx;
                        end
                    end
                    if (last) {dut_a, dut_b, dut_x} <= '0;
                    else idx <= idx + 1'b1;
                end
                DONE: pass <= err_count == '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_vector_driver.sv
// tb_tt_vector_driver: drives two driver instances (ERR_W=4 and ERR_W=2) against a
// modelled truth table and checks each run against a run-level reference model.
module tb_tt_vector_driver;
    logic clk = 0, rst = 1, vec_we = 0, start = 0;
    logic [2:0] vec_waddr = '0;
    logic [10:0] vec_wdata = '0;
    logic [3:0] num_vec = '0;
    logic [2:0] a0, a1, y0, y1, fi0, fi1;
    logic [3:0] b0, b1, err0;
    logic [1:0] err1;
    logic x0, x1, busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
    logic [2:0] tt [256];
    logic [10:0] tbl_m [8];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign y0 = tt[{a0, b0, x0}];
    assign y1 = tt[{a1, b1, x1}];

    tt_vector_driver #(.ERR_W(4)) u0 (.clk(clk), .rst(rst), .vec_we(vec_we), .vec_waddr(vec_waddr),
        .vec_wdata(vec_wdata), .num_vec(num_vec), .start(start), .dut_a(a0), .dut_b(b0), .dut_x(x0),
        .dut_y(y0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_vld(fv0), .first_err_idx(fi0));
    tt_vector_driver #(.ERR_W(2)) u1 (.clk(clk), .rst(rst), .vec_we(vec_we), .vec_waddr(vec_waddr),
        .vec_wdata(vec_wdata), .num_vec(num_vec), .start(start), .dut_a(a1), .dut_b(b1), .dut_x(x1),
        .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_vld(fv1), .first_err_idx(fi1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [10:0] mkv(int a, int b, int x, int y);
        return {a[2:0], b[3:0], x[0], y[2:0]};
    endfunction

    task automatic wr(input int adr, input logic [10:0] d);
        vec_we = 1; vec_waddr = adr[2:0]; vec_wdata = d;
        step();
        vec_we = 0;
        tbl_m[adr] = d;
    endtask

    // Expected outcome of a run is computed from the table and truth-table contents alone.
    task automatic run_check(input string tag, input int n, input bit we, input int wa, input logic [10:0] wd);
        int cnt, e, fi, lat;
        bit fv, busy_seen;
        if (we) begin
            vec_we = 1; vec_waddr = wa[2:0]; vec_wdata = wd; tbl_m[wa] = wd;
        end
        cnt = n > 8 ? 8 : n;
        e = 0; fv = 0; fi = 0;
        for (int i = 0; i < cnt; i++)
            if (tt[tbl_m[i][10:3]] != tbl_m[i][2:0]) begin
                e++;
                if (!fv) begin fv = 1; fi = i; end
            end
        num_vec = n[3:0]; start = 1; lat = 0; busy_seen = 0;
        do begin
            step();
            start = 0; vec_we = 0;
            lat++;
            busy_seen |= busy0;
        end while (!done0 && lat < 300);
        chk({tag, ".latency"}, lat, cnt == 0 ? 1 : 1 + cnt * 3);
        chk({tag, ".done1"}, done1, 1);
        chk({tag, ".err4"}, err0, e > 15 ? 15 : e);
        chk({tag, ".err2"}, err1, e > 3 ? 3 : e);
        chk({tag, ".fv"}, {fv1, fv0}, {fv, fv});
        chk({tag, ".fidx"}, {fi1, fi0}, {fi[2:0], fi[2:0]});
        if (cnt == 0) chk({tag, ".busy_never"}, busy_seen, 0);
        step();
        chk({tag, ".pass"}, {pass1, pass0}, {e == 0, e == 0});
        chk({tag, ".idle"}, {done0, busy0, a0, b0, x0}, 0);
        chk({tag, ".held_err"}, err0, e > 15 ? 15 : e);
    endtask

    initial begin
        int lat, dones;
        for (int i = 0; i < 256; i++) tt[i] = 3'($urandom);
        repeat (2) step();
        chk("reset_outputs", {busy0, done0, pass0, err0, fv0, fi0, a0, b0, x0}, 0);
        chk("reset_outputs_w2", {busy1, done1, pass1, err1, fv1, fi1}, 0);
        rst = 0;
        step();
        // directed table with a consistent truth table
        tt[{3'd7, 4'd2, 1'b1}] = 2; tt[{3'd4, 4'd1, 1'b0}] = 3; tt[{3'd3, 4'd1, 1'b0}] = 2;
        tt[{3'd3, 4'd4, 1'b1}] = 0; tt[{3'd0, 4'd4, 1'b1}] = 1;
        wr(0, mkv(7, 2, 1, 2)); wr(1, mkv(4, 1, 0, 3)); wr(2, mkv(3, 1, 0, 2));
        wr(3, mkv(3, 4, 1, 0)); wr(4, mkv(0, 4, 1, 1));
        run_check("t1_good", 5, 0, 0, 0);
        wr(2, mkv(3, 1, 0, 5));
        run_check("t2_slot2_bad", 5, 0, 0, 0);
        chk("t2_fidx_literal", fi0, 2);
        run_check("t3_zero", 0, 0, 0, 0);
        wr(2, mkv(3, 1, 0, 2));
        // reset during WAIT of vector 3 (cycle T+11)
        num_vec = 5; start = 1; lat = 0;
        do begin step(); start = 0; lat++; end while (lat < 11);
        chk("t4_in_wait_busy", busy0, 1);
        rst = 1;
        step();
        rst = 0;
        chk("t4_abort", {busy0, done0, a0, b0, x0, err0, pass0}, 0);
        dones = 0;
        repeat (25) begin step(); dones += done0; end
        chk("t4_no_done", dones, 0);
        run_check("t4_rerun", 5, 0, 0, 0);
        // start held high and table write attempted mid-run
        num_vec = 2; start = 1; lat = 0; dones = 0;
        do begin
            step(); lat++;
            if (lat == 3) begin vec_we = 1; vec_waddr = 0; vec_wdata = mkv(7, 2, 1, 6); end
            else vec_we = 0;
        end while (!done0 && lat < 300);
        start = 0; vec_we = 0;
        chk("t5_latency", lat, 7);
        repeat (15) begin step(); dones += done0 | busy0; end
        chk("t5_single_run", dones, 0);
        run_check("t5_readback", 1, 0, 0, 0);
        // same-cycle write and start
        run_check("t5b_write_start", 1, 1, 0, mkv(7, 2, 1, 4));
        wr(0, mkv(7, 2, 1, 2));
        // all slots wrong, clamped count, saturation on the narrow counter
        for (int i = 0; i < 8; i++) begin
            logic [10:0] v;
            v = 11'($urandom);
            v[2:0] = tt[v[10:3]] ^ 3'(1 + $urandom_range(0, 6));
            wr(i, v);
        end
        run_check("t6_sat", 9, 0, 0, 0);
        chk("t6_err2_literal", err1, 3);
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 8; i++) begin
                logic [10:0] v;
                v = 11'($urandom);
                v[2:0] = $urandom_range(0, 3) == 0 ? 3'($urandom) : tt[v[10:3]];
                wr(i, v);
            end
            run_check($sformatf("rand%0d", r), $urandom_range(0, 12), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7), 11'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
